outarb: RTL and testbench



---
 rtl/outarb_pkg.sv | 26 ++
 rtl/outarb_if.sv | 32 +++
 rtl/outarb_rr_pick.sv | 34 +++
 rtl/outarb.sv | 115 +++++++++++
 tb/tb_outarb.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outarb_pkg.sv
// Shared definitions for the output-port switch arbiter: flit type codes,
// default widths/counts and enable polarity constants.
package outarb_pkg;

    localparam int NPORT_DEF = 5;
    localparam int NVCH_DEF  = 2;
    localparam int VCHW_DEF  = 1;
    localparam int TYPEW_DEF = 2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic ENABLE_ = 1'b0;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'd0,
        FT_BODY     = 2'd1,
        FT_TAIL     = 2'd2,
        FT_HEADTAIL = 2'd3
    } flit_t;

    // Body/tail flits continue a packet that already owns its VC.
    function automatic logic is_cont(flit_t t);
        return (t == FT_BODY) || (t == FT_TAIL);
    endfunction

endpackage

// File: rtl/outarb_if.sv
// Request/grant bundle between the input ports, the output channel and outarb.
interface outarb_if
    import outarb_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int NVCH  = NVCH_DEF,
    parameter int VCHW  = VCHW_DEF,
    parameter int TYPEW = TYPEW_DEF,
    parameter int SELW  = 3
) ();

    logic [NPORT-1:0]       ireq;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT*TYPEW-1:0] itype;
    logic [NVCH-1:0]        ordy;
    logic [NPORT-1:0]       ogrant;
    logic                   ovalid;
    logic [SELW-1:0]        osel;
    logic [VCHW-1:0]        ovch;
    logic [NVCH-1:0]        olck;

    modport master (
        output ireq, ivch, itype, ordy,
        input  ogrant, ovalid, osel, ovch, olck
    );

    modport slave (
        input  ireq, ivch, itype, ordy,
        output ogrant, ovalid, osel, ovch, olck
    );

endinterface

// File: rtl/outarb_rr_pick.sv
// Combinational round-robin picker: first set bit of elig searching upward
// from ptr, wrapping modulo N. Returns one-hot, index and a found flag.
module rr_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int unsigned k;
        logic [W-1:0] kk;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        kk     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) k = k - N;
            kk = W'(k);
            if (!any && elig[kk]) begin
                any        = 1'b1;
                onehot[kk] = 1'b1;
                idx        = kk;
            end
        end
    end

endmodule

// File: rtl/outarb.sv
// Per-output switch arbiter with per-VC wormhole locking and round-robin
// selection. Define OUTARB_ERRCHK_EN to add the sticky protocol-error output oerr.
module outarb
    import outarb_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int NPORT    = NPORT_DEF,
    parameter int NVCH     = NVCH_DEF,
    parameter int VCHW     = VCHW_DEF,
    parameter int TYPEW    = TYPEW_DEF,
    parameter int SELW     = 3
) (
    input  logic    clk,
    input  logic    rst_,
    outarb_if.slave bus
`ifdef OUTARB_ERRCHK_EN
    ,
    output logic    oerr
`endif
);

    if (NPORT < 2 || (1 << SELW) < NPORT || (1 << VCHW) < NVCH ||
        ROUTERID < 0 || PCHID < 0) begin : g_bad_cfg
        $error("outarb: inconsistent parameters");
    end

    logic [NVCH-1:0]  lck;
    logic [SELW-1:0]  owner [NVCH];
    logic [SELW-1:0]  rrptr;

    logic [NPORT-1:0] elig;
    logic [NPORT-1:0] win_oh;
    logic [SELW-1:0]  win_idx;
    logic             win_any;
    logic             run;
    logic             valid;
    logic [VCHW-1:0]  wvch;
    flit_t            wtype;

`ifdef OUTARB_ERRCHK_EN
    logic [NPORT-1:0] bad;
`endif

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [VCHW-1:0] v;
        flit_t           t;
        assign v = bus.ivch[p*VCHW +: VCHW];
        assign t = flit_t'(bus.itype[p*TYPEW +: TYPEW]);
        // Continuations need ownership; heads need a free VC with downstream room.
        assign elig[p] = bus.ireq[p] &
                         (is_cont(t) ? (lck[v] & (owner[v] == SELW'(p)))
                                     : (~lck[v] & bus.ordy[v]));
`ifdef OUTARB_ERRCHK_EN
        assign bad[p] = bus.ireq[p] & is_cont(t) &
                        (~lck[v] | (owner[v] != SELW'(p)));
`endif
    end

    rr_pick #(
        .N (NPORT),
        .W (SELW)
    ) u_pick (
        .elig   (elig),
        .ptr    (rrptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign run   = (rst_ != ENABLE_);
    assign valid = run & win_any;
    assign wvch  = bus.ivch[win_idx*VCHW +: VCHW];
    assign wtype = flit_t'(bus.itype[win_idx*TYPEW +: TYPEW]);

    assign bus.ovalid = valid;
    assign bus.ogrant = valid ? win_oh  : '0;
    assign bus.osel   = valid ? win_idx : '0;
    assign bus.ovch   = valid ? wvch    : '0;
    assign bus.olck   = lck;

    always_ff @(posedge clk or negedge rst_) begin
        if (rst_ == ENABLE_) begin
            lck   <= '0;
            rrptr <= '0;
            for (int unsigned v = 0; v < NVCH; v++) owner[v] <= '0;
        end else if (valid) begin
            rrptr <= (win_idx == SELW'(NPORT-1)) ? '0 : win_idx + 1'b1;
            case (wtype)
                FT_HEAD: begin
                    lck[wvch]   <= ENABLE;
                    owner[wvch] <= win_idx;
                end
                FT_TAIL: lck[wvch] <= DISABLE;
                default: ;
            endcase
        end
    end

`ifdef OUTARB_ERRCHK_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (rst_ == ENABLE_) begin
            oerr <= 1'b0;
        end else if (|bad) begin
            oerr <= 1'b1;
`ifndef SYNTHESIS
            if (!oerr)
                $display("outarb r%0d p%0d: continuation flit without VC ownership, ports=%b",
                         ROUTERID, PCHID, bad);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_outarb.sv
// Self-checking bench for outarb: directed scenarios plus randomized packet
// traffic compared cycle by cycle against a behavioural arbiter model.
module tb_outarb;
    import outarb_pkg::*;

    localparam int NP = 5;
    localparam int NV = 2;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    outarb_if #(.NPORT(NP), .NVCH(NV), .VCHW(1), .TYPEW(2), .SELW(3)) bus ();

`ifdef OUTARB_ERRCHK_EN
    logic oerr;
`endif

    outarb #(
        .ROUTERID (0),
        .PCHID    (0),
        .NPORT    (NP),
        .NVCH     (NV),
        .VCHW     (1),
        .TYPEW    (2),
        .SELW     (3)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
`ifdef OUTARB_ERRCHK_EN
        ,
        .oerr (oerr)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // stimulus state: one packet generator per input port
    bit    req_a [NP];
    int    vc_a  [NP];
    flit_t ty_a  [NP];
    bit    g_act [NP];
    int    g_len [NP];
    int    g_pos [NP];
    logic [1:0] ordy_a;

    // reference model state
    int m_lck [NV];
    int m_own [NV];
    int m_rr;

    logic [4:0] g_grant;
    logic       g_valid;
    logic [2:0] g_sel;
    logic       g_vch;
    int         cnt [NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ty(input int p);
        if (g_len[p] == 1)               ty_a[p] = FT_HEADTAIL;
        else if (g_pos[p] == 0)          ty_a[p] = FT_HEAD;
        else if (g_pos[p] == g_len[p]-1) ty_a[p] = FT_TAIL;
        else                             ty_a[p] = FT_BODY;
    endtask

    task automatic start_pkt(input int p, input int vc, input int len);
        g_act[p] = 1'b1;
        g_len[p] = len;
        g_pos[p] = 0;
        vc_a[p]  = vc;
        req_a[p] = 1'b1;
        set_ty(p);
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            g_act[p] = 1'b0;
            req_a[p] = 1'b0;
            vc_a[p]  = 0;
            ty_a[p]  = FT_HEAD;
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_lck[v] = 0;
            m_own[v] = 0;
        end
        m_rr = 0;
    endtask

    task automatic apply();
        for (int p = 0; p < NP; p++) begin
            bus.ireq[p]         = req_a[p];
            bus.ivch[p]         = 1'(vc_a[p]);
            bus.itype[p*2 +: 2] = ty_a[p];
        end
        bus.ordy = ordy_a;
    endtask

    function automatic bit elig_m(int p);
        int v = vc_a[p];
        if (!req_a[p]) return 1'b0;
        if (ty_a[p] == FT_BODY || ty_a[p] == FT_TAIL)
            return (m_lck[v] == 1) && (m_own[v] == p);
        return (m_lck[v] == 0) && ordy_a[v];
    endfunction

    function automatic int model_winner();
        int win = -1;
        for (int k = 0; k < NP; k++) begin
            int p = (m_rr + k) % NP;
            if (win < 0 && elig_m(p)) win = p;
        end
        return win;
    endfunction

    task automatic model_commit(input int win);
        int v;
        if (win < 0) return;
        v = vc_a[win];
        if (ty_a[win] == FT_HEAD) begin
            m_lck[v] = 1;
            m_own[v] = win;
        end else if (ty_a[win] == FT_TAIL) begin
            m_lck[v] = 0;
        end
        m_rr = (win + 1) % NP;
    endtask

    task automatic advance(input int win);
        if (win < 0) return;
        g_pos[win]++;
        if (g_pos[win] >= g_len[win]) begin
            g_act[win] = 1'b0;
            req_a[win] = 1'b0;
        end else begin
            set_ty(win);
        end
    endtask

    // One clock: drive, check combinational outputs mid-cycle, commit at the edge.
    task automatic cycle();
        int win;
        apply();
        @(negedge clk);
        win     = model_winner();
        g_grant = bus.ogrant;
        g_valid = bus.ovalid;
        g_sel   = bus.osel;
        g_vch   = bus.ovch;
        chk("ogrant", 32'(g_grant), (win < 0) ? 0 : (1 << win));
        chk("ovalid", 32'(g_valid), (win >= 0) ? 1 : 0);
        chk("osel",   32'(g_sel),   (win < 0) ? 0 : win);
        chk("ovch",   32'(g_vch),   (win < 0) ? 0 : vc_a[win]);
        chk("olck",   32'(bus.olck), m_lck[1]*2 + m_lck[0]);
        @(posedge clk);
        model_commit(win);
        advance(win);
        #1;
    endtask

    task automatic reset_all();
        rst_ = 1'b0;
        clear_all();
        model_clear();
        apply();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_   = 1'b0;
        ordy_a = 2'b11;
        clear_all();
        model_clear();
        for (int p = 0; p < NP; p++) start_pkt(p, 0, 1);
        apply();
        #12;
        chk("rst_ogrant", 32'(bus.ogrant), 0);
        chk("rst_ovalid", 32'(bus.ovalid), 0);
        chk("rst_osel",   32'(bus.osel), 0);
        chk("rst_ovch",   32'(bus.ovch), 0);
        chk("rst_olck",   32'(bus.olck), 0);
        clear_all();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;

        // single HEADTAIL, then the pointer has moved past port 2
        start_pkt(2, 0, 1);
        cycle();
        chk("ht_grant", 32'(g_grant), 32'b00100);
        chk("ht_olck",  32'(bus.olck), 0);
        for (int p = 0; p < NP; p++) start_pkt(p, 0, 1);
        cycle();
        chk("ht_rr", 32'(g_sel), 3);
        clear_all();

        // wormhole lock on VC1
        start_pkt(1, 1, 3);
        start_pkt(3, 1, 2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wh_p1", 32'(g_sel), 1);
            chk("wh_p3_blocked", 32'(g_grant[3]), 0);
        end
        cycle();
        chk("wh_p3_head", 32'(g_grant), 32'b01000);
        cycle();
        chk("wh_p3_tail", 32'(g_grant), 32'b01000);

        // VC interleave from rrptr=0
        reset_all();
        start_pkt(0, 0, 4);
        start_pkt(4, 1, 4);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("ilv_order", 32'(g_sel), (i % 2) ? 4 : 0);
        end
        chk("ilv_unlock", 32'(bus.olck), 0);

        // credit gate: heads wait on ordy, body/tail do not
        ordy_a = 2'b00;
        start_pkt(1, 0, 3);
        cycle();
        chk("cg_block", 32'(g_valid), 0);
        ordy_a = 2'b01;
        cycle();
        chk("cg_head", 32'(g_grant), 32'b00010);
        ordy_a = 2'b00;
        cycle();
        chk("cg_body", 32'(g_grant), 32'b00010);
        cycle();
        chk("cg_tail", 32'(g_grant), 32'b00010);
        ordy_a = 2'b11;

        // fairness
        reset_all();
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int i = 0; i < 50; i++) begin
            for (int p = 0; p < NP; p++) if (!g_act[p]) start_pkt(p, 0, 1);
            cycle();
            if (i < 6) chk("fair_order", 32'(g_sel), i % 5);
            if (g_valid) cnt[g_sel]++;
        end
        for (int p = 0; p < NP; p++) chk("fair_cnt", cnt[p], 10);
        clear_all();

        // asynchronous reset mid-packet
        start_pkt(0, 0, 3);
        cycle();
        chk("ar_pre_lck", 32'(bus.olck), 1);
        apply();
        #2;
        rst_ = 1'b0;
        #1;
        chk("ar_olck",   32'(bus.olck), 0);
        chk("ar_ogrant", 32'(bus.ogrant), 0);
        chk("ar_ovalid", 32'(bus.ovalid), 0);
        clear_all();
        model_clear();
        apply();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        start_pkt(3, 0, 2);
        cycle();
        chk("ar_new_head", 32'(g_grant), 32'b01000);
        cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!g_act[p]) begin
                    if ($urandom_range(3) == 0)
                        start_pkt(p, int'($urandom_range(1)), int'($urandom_range(4, 1)));
                end else begin
                    req_a[p] = ($urandom_range(4) != 0);
                end
            end
            ordy_a = 2'($urandom_range(3));
            cycle();
        end

`ifdef OUTARB_ERRCHK_EN
        chk("oerr_clean", 32'(oerr), 0);
        reset_all();
        g_act[2] = 1'b1;
        g_len[2] = 3;
        g_pos[2] = 1;
        vc_a[2]  = 0;
        req_a[2] = 1'b1;
        set_ty(2);
        cycle();
        chk("oerr_set", 32'(oerr), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
